// File: rtl/ss_scan_mux.sv
// Time-multiplexes a double-buffered 16-bit word onto a 4-digit common-anode display, one nibble per slot.
// bcd/an/digit_idx follow idx combinationally; frame_tick/upd_pend are registered; no backpressure.
module ss_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx,
  output logic        frame_tick,
  output logic        upd_pend
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp_reg;
  logic [15:0]   pend_reg;
  logic          slot_end;
  logic          frame_end;
  logic [3:0]    lz;
  logic          dig_off;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd0;
      disp_reg   <= 16'h0000;
      pend_reg   <= 16'h0000;
      upd_pend   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      frame_tick <= frame_end;
      if (slot_end)
        idx <= idx + 2'd1;
      if (frame_end && upd_pend) begin
        disp_reg <= pend_reg;
        upd_pend <= 1'b0;
      end
      // A load on the frame edge lands after the swap, so it waits for the next frame.
      if (load) begin
        pend_reg <= value;
        upd_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    lz      = 4'b0000;
    lz[3]   = (disp_reg[15:12] == 4'h0);
    lz[2]   = (disp_reg[15:8]  == 8'h00);
    lz[1]   = (disp_reg[15:4]  == 12'h000);
    dig_off = blank || (LZ_BLANK && lz[idx]);
    bcd       = disp_reg[{idx, 2'b00} +: 4];
    an        = dig_off ? 4'b1111 : ~(4'b0001 << idx);
    digit_idx = idx;
  end

endmodule
